// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Purpose:
//   Grants a single-master bus interconnect to one of two masters (m0 =
//   processor, m1 = DMA / program loader). The owner's request is forwarded
//   combinationally to the interconnect; read data is captured into a
//   per-master register with a one-cycle valid pulse. An owner keeps the bus
//   for up to MAX_BURST consecutive cycles while the other master waits, then
//   the bus is handed over with no idle cycle in between.
//
// Build option:
//   BUS_ARB_RR_EN  defined   -> a tie in IDLE goes to the master that was not
//                               granted last (round-robin).
//                  undefined -> a tie in IDLE always goes to m0.
//
// Parameters:
//   MAX_BURST      consecutive granted cycles under contention (>= 1)
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst_n          synchronous reset, active low
//   mX_req_i       master X requests an access (payload stable while high)
//   mX_rd_en_i     read strobe of master X
//   mX_wr_en_i     write strobe of master X
//   mX_addr_i      address of master X
//   mX_data_i      write data of master X
//   mX_gnt_o       registered grant to master X
//   mX_data_o      last read data captured for master X
//   mX_rvalid_o    one-cycle pulse the cycle after a completed read by X
//   bus_rd_en_o    read enable to the interconnect
//   bus_wr_en_o    write enable to the interconnect
//   bus_addr_o     address to the interconnect
//   bus_data_o     write data to the interconnect
//   bus_data_i     read data from the interconnect (same-cycle)
//   bus_owner_o    00 idle, 01 m0, 10 m1
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req_i,
    input  logic        m0_rd_en_i,
    input  logic        m0_wr_en_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_gnt_o,
    output logic [31:0] m0_data_o,
    output logic        m0_rvalid_o,

    input  logic        m1_req_i,
    input  logic        m1_rd_en_i,
    input  logic        m1_wr_en_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_gnt_o,
    output logic [31:0] m1_data_o,
    output logic        m1_rvalid_o,

    output logic        bus_rd_en_o,
    output logic        bus_wr_en_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    output logic [1:0]  bus_owner_o
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    // Encoding doubles as the one-hot grant vector and the owner code.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Per-master views so the datapath can be indexed by master number.
    logic [1:0]  req_a;
    logic [1:0]  rd_a;
    logic [1:0]  wr_a;
    logic [31:0] addr_a  [2];
    logic [31:0] wdata_a [2];

    assign req_a      = {m1_req_i,   m0_req_i};
    assign rd_a       = {m1_rd_en_i, m0_rd_en_i};
    assign wr_a       = {m1_wr_en_i, m0_wr_en_i};
    assign addr_a[0]  = m0_addr_i;
    assign addr_a[1]  = m1_addr_i;
    assign wdata_a[0] = m0_data_i;
    assign wdata_a[1] = m1_data_i;

    logic [1:0] gnt;
    assign gnt = state_q;

    // ------------------------------------------------------------------
    // Tie-break winner from IDLE
    // ------------------------------------------------------------------
    state_e tie_win;

`ifdef BUS_ARB_RR_EN
    // 1 = m1 was the most recently granted master. Reset to 1 so the first
    // tie after reset goes to m0.
    logic last_q, last_d;

    assign tie_win = last_q ? OWN0 : OWN1;

    always_comb begin
        last_d = last_q;
        if (state_d != state_q) begin
            if (state_d == OWN0) begin
                last_d = 1'b0;
            end else if (state_d == OWN1) begin
                last_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign tie_win = OWN0;
`endif

    // ------------------------------------------------------------------
    // Ownership FSM and burst counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_a[0] && req_a[1]) begin
                    state_d = tie_win;
                end else if (req_a[0]) begin
                    state_d = OWN0;
                end else if (req_a[1]) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req_a[0]) begin
                    state_d = req_a[1] ? OWN1 : IDLE;
                end else if (req_a[1] && (cnt_q == CNT_MAX)) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!req_a[1]) begin
                    state_d = req_a[0] ? OWN0 : IDLE;
                end else if (req_a[0] && (cnt_q == CNT_MAX)) begin
                    state_d = OWN0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts accesses of the current tenure; it saturates so a lone owner
    // can hold the bus indefinitely and still hand over on the next cycle
    // the other master shows up.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q != IDLE) && ((gnt & req_a) != 2'b00)
                     && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus forwarding: zero everything unless the owner is actively asking.
    // ------------------------------------------------------------------
    logic own_sel;
    logic own_act;

    assign own_sel = state_q[1];
    assign own_act = (state_q != IDLE) && req_a[own_sel];

    always_comb begin
        bus_rd_en_o = 1'b0;
        bus_wr_en_o = 1'b0;
        bus_addr_o  = '0;
        bus_data_o  = '0;
        if (own_act) begin
            bus_rd_en_o = rd_a[own_sel];
            bus_wr_en_o = wr_a[own_sel];
            bus_addr_o  = addr_a[own_sel];
            bus_data_o  = wdata_a[own_sel];
        end
    end

    // ------------------------------------------------------------------
    // Per-master read capture
    // ------------------------------------------------------------------
    logic [1:0][31:0] rdata_w;
    logic [1:0]       rvalid_w;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic        rd_done;
        logic [31:0] data_q;
        logic        rvalid_q;

        assign rd_done = gnt[gi] & req_a[gi] & rd_a[gi];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_q   <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_done;
                if (rd_done) begin
                    data_q <= bus_data_i;
                end
            end
        end

        assign rdata_w[gi]  = data_q;
        assign rvalid_w[gi] = rvalid_q;
    end

    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign m0_data_o   = rdata_w[0];
    assign m1_data_o   = rdata_w[1];
    assign m0_rvalid_o = rvalid_w[0];
    assign m1_rvalid_o = rvalid_w[1];
    assign bus_owner_o = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter. A behavioural model (owner number,
// unsaturated tenure length, last-granted master, captured read data) predicts
// every output each cycle; directed scenarios add literal expectations.
// Honours BUS_ARB_RR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req, rd, wr;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] bus_data;

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_data, m1_data;
    logic        bus_rd_en, bus_wr_en;
    logic [31:0] bus_addr, bus_wdata;
    logic [1:0]  bus_owner;

    bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_req_i    (req[0]),
        .m0_rd_en_i  (rd[0]),
        .m0_wr_en_i  (wr[0]),
        .m0_addr_i   (addr[0]),
        .m0_data_i   (wdata[0]),
        .m0_gnt_o    (m0_gnt),
        .m0_data_o   (m0_data),
        .m0_rvalid_o (m0_rvalid),
        .m1_req_i    (req[1]),
        .m1_rd_en_i  (rd[1]),
        .m1_wr_en_i  (wr[1]),
        .m1_addr_i   (addr[1]),
        .m1_data_i   (wdata[1]),
        .m1_gnt_o    (m1_gnt),
        .m1_data_o   (m1_data),
        .m1_rvalid_o (m1_rvalid),
        .bus_rd_en_o (bus_rd_en),
        .bus_wr_en_o (bus_wr_en),
        .bus_addr_o  (bus_addr),
        .bus_data_o  (bus_wdata),
        .bus_data_i  (bus_data),
        .bus_owner_o (bus_owner)
    );

    // ---------------- behavioural model ----------------
    int          mo_owner;      // 0 none, 1 m0, 2 m1
    int          mo_tenure;     // accesses completed in current tenure
    int          mo_last;       // index of last granted master
    logic [31:0] mo_rdata [2];
    bit          mo_rvalid [2];
    bit          mo_done [2];   // master completed an access last cycle

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mo_owner  = 0;
        mo_tenure = 0;
        mo_last   = 1;
        for (int k = 0; k < 2; k++) begin
            mo_rdata[k]  = '0;
            mo_rvalid[k] = 1'b0;
            mo_done[k]   = 1'b0;
        end
    endtask

    // Compare every DUT output with what the model says for this cycle.
    task automatic compare_all();
        logic        e_rd, e_wr;
        logic [31:0] e_addr, e_wd;
        int          x;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
        if (mo_owner != 0) begin
            x = mo_owner - 1;
            if (req[x]) begin
                e_rd   = rd[x];
                e_wr   = wr[x];
                e_addr = addr[x];
                e_wd   = wdata[x];
            end
        end
        chk("m0_gnt",    32'(m0_gnt),    32'(mo_owner == 1));
        chk("m1_gnt",    32'(m1_gnt),    32'(mo_owner == 2));
        chk("bus_owner", 32'(bus_owner), 32'(mo_owner));
        chk("bus_rd_en", 32'(bus_rd_en), 32'(e_rd));
        chk("bus_wr_en", 32'(bus_wr_en), 32'(e_wr));
        chk("bus_addr",  bus_addr,       e_addr);
        chk("bus_data",  bus_wdata,      e_wd);
        chk("m0_data",   m0_data,        mo_rdata[0]);
        chk("m1_data",   m1_data,        mo_rdata[1]);
        chk("m0_rvalid", 32'(m0_rvalid), 32'(mo_rvalid[0]));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(mo_rvalid[1]));
    endtask

    // Advance the model across one rising edge using the present inputs.
    task automatic model_step();
        int nxt, x, y;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            mo_done[k]   = (mo_owner == k + 1) && req[k];
            mo_rvalid[k] = mo_done[k] && rd[k];
            if (mo_rvalid[k]) mo_rdata[k] = bus_data;
            if (mo_done[k])
                $display("access m%0d rd=%0b wr=%0b addr=0x%08h wdata=0x%08h rdata=0x%08h",
                         k, rd[k], wr[k], addr[k], wdata[k], bus_data);
        end
        if (mo_owner == 0) begin
            if (req == 2'b11) begin
`ifdef BUS_ARB_RR_EN
                nxt = (mo_last == 1) ? 1 : 2;
`else
                nxt = 1;
`endif
            end else if (req[0]) nxt = 1;
            else if (req[1])     nxt = 2;
            else                 nxt = 0;
        end else begin
            x = mo_owner - 1;
            y = 1 - x;
            if (!req[x])                                         nxt = req[y] ? y + 1 : 0;
            else if (req[y] && (mo_tenure + 1 >= MAX_BURST))     nxt = y + 1;
            else                                                 nxt = mo_owner;
        end
        if (nxt != mo_owner) begin
            mo_tenure = 0;
            if (nxt != 0) mo_last = nxt - 1;
        end else if (mo_owner != 0) begin
            mo_tenure++;
        end
        mo_owner = nxt;
    endtask

    // One clock cycle: check outputs against the model, then cross the edge.
    task automatic tick();
        #1;
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        req = '0; rd = '0; wr = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        bus_data = '0;

        // ---------------- reset state ----------------
        @(posedge clk);
        #1;
        model_reset();
        $display("test reset_state");
        chk("rst_m0_gnt",    32'(m0_gnt),    32'd0);
        chk("rst_m1_gnt",    32'(m1_gnt),    32'd0);
        chk("rst_owner",     32'(bus_owner), 32'd0);
        chk("rst_m0_data",   m0_data,        32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_bus_addr",  bus_addr,       32'd0);
        tick();
        rst_n = 1'b1;

        // ---------------- contention, m0x4 m1x4 m0x4 ----------------
        $display("test contention");
        req = 2'b11; rd = 2'b11; addr[0] = 32'h0000_00A0; addr[1] = 32'h0000_00B0;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk("cont_owner", 32'(bus_owner), (i < 4 || i >= 8) ? 32'd1 : 32'd2);
            chk("cont_addr",  bus_addr, (i < 4 || i >= 8) ? 32'h0000_00A0 : 32'h0000_00B0);
            bus_data = $urandom;
            tick();
        end
        req = '0; rd = '0;
        tick();

        // ---------------- single master read ----------------
        $display("test single_read");
        req = 2'b01; rd = 2'b01; addr[0] = 32'h0000_0010; bus_data = 32'hDEAD_BEEF;
        tick();                                       // cycle N
        chk("rd_m0_gnt_n1", 32'(m0_gnt), 32'd1);      // N+1
        chk("rd_bus_addr",  bus_addr, 32'h0000_0010);
        tick();
        req = '0; rd = '0;                            // N+2
        chk("rd_m0_data",   m0_data, 32'hDEAD_BEEF);
        chk("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
        tick();
        chk("rd_rvalid_pulse", 32'(m0_rvalid), 32'd0);
        chk("rd_m0_hold",      m0_data, 32'hDEAD_BEEF);

        // ---------------- tie after release ----------------
        $display("test tie_release");
        req = 2'b01; tick(); req = '0; tick();        // m0 last
        req = 2'b11; tick();
`ifdef BUS_ARB_RR_EN
        chk("tie_m0_last", 32'(bus_owner), 32'd2);
`else
        chk("tie_m0_last", 32'(bus_owner), 32'd1);
`endif
        req = '0; tick();
        req = 2'b10; tick(); req = '0; tick();        // m1 last
        req = 2'b11; tick();
        chk("tie_m1_last", 32'(bus_owner), 32'd1);
        req = '0; tick();

        // ---------------- write path ----------------
        $display("test write");
        req = 2'b10; wr = 2'b10; addr[1] = 32'h8000_0000; wdata[1] = 32'h0000_00A5;
        tick();
        chk("wr_m1_gnt",  32'(m1_gnt), 32'd1);
        chk("wr_wr_en",   32'(bus_wr_en), 32'd1);
        chk("wr_data",    bus_wdata, 32'h0000_00A5);
        chk("wr_addr",    bus_addr, 32'h8000_0000);
        req = '0; wr = '0;
        #1;
        chk("wr_en_one_cycle", 32'(bus_wr_en), 32'd0);
        tick();
        chk("wr_no_rvalid", 32'(m1_rvalid), 32'd0);

        // ---------------- early release ----------------
        $display("test early_release");
        req = 2'b11; rd = 2'b11; addr[0] = 32'h0000_0100; addr[1] = 32'h0000_0200;
        tick();
        chk("er_first_m0", 32'(bus_owner), 32'd1);
        tick();
        tick();
        req[0] = 1'b0;
        chk("er_still_m0", 32'(m0_gnt), 32'd1);
        tick();
        chk("er_handover", 32'(bus_owner), 32'd2);
        req[0] = 1'b1;
        n = 0;
        while (bus_owner == 2'd2 && n < 20) begin
            n++;
            tick();
        end
        chk("er_m1_full_burst", 32'(n), 32'(MAX_BURST));
        req = '0; rd = '0;
        tick();

        // ---------------- reset mid-burst ----------------
        $display("test reset_mid_burst");
        req = 2'b10; rd = 2'b10; addr[1] = 32'h0000_0300; bus_data = 32'h1234_5678;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mr_owner",     32'(bus_owner), 32'd0);
        chk("mr_m1_gnt",    32'(m1_gnt),    32'd0);
        chk("mr_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("mr_m1_data",   m1_data,        32'd0);
        chk("mr_bus_rd_en", 32'(bus_rd_en), 32'd0);
        chk("mr_bus_addr",  bus_addr,       32'd0);
        rst_n = 1'b1; req = 2'b11;
        tick();
        chk("mr_first_tie", 32'(bus_owner), 32'd1);
        req = '0; rd = '0;
        tick();

        // ---------------- randomized traffic ----------------
        $display("test random");
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            for (int k = 0; k < 2; k++) begin
                if (!req[k] || mo_done[k]) begin
                    rd[k]    = 1'($urandom_range(0, 1));
                    wr[k]    = 1'($urandom_range(0, 1));
                    addr[k]  = $urandom;
                    wdata[k] = $urandom;
                end
                req[k] = ($urandom_range(0, 9) < 7);
            end
            bus_data = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
